// File: rtl/universal_register_pkg.sv
// rtl/universal_register_pkg.sv - mode encodings shared by the register and its users
package universal_register_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_SHL  = 3'b011;
  localparam mode_t MODE_ROR  = 3'b100;
  localparam mode_t MODE_ROL  = 3'b101;
  localparam mode_t MODE_INC  = 3'b110;
  localparam mode_t MODE_DEC  = 3'b111;

endpackage

// File: rtl/universal_register_if.sv
// rtl/universal_register_if.sv - control, data and status bundle of the universal register
interface universal_register_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sil;
  logic             sir;
  logic [WIDTH-1:0] q;
  logic             so;
  logic             co;
  logic             zero;

  modport master (
    output en, mode, d, sil, sir,
    input  q, so, co, zero
  );

  modport slave (
    input  en, mode, d, sil, sir,
    output q, so, co, zero
  );

endinterface

// File: rtl/dff_sre.sv
// rtl/dff_sre.sv - single-bit rising-edge D flip-flop with synchronous reset and enable
module dff_sre (
  input  logic c,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge c) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/universal_register.sv
// rtl/universal_register.sv - WIDTH-bit hold/load/shift/rotate/count register built from dff_sre cells
module universal_register
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                c,
  input  logic                rst,
  universal_register_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic             co_r;
  logic [WIDTH-1:0] next_q;
  logic             next_so;
  logic             next_co;
  logic [WIDTH:0]   inc_full;
  logic [WIDTH:0]   dec_full;

  // The extra top bit of the widened sum/difference is the carry or borrow out.
  assign inc_full = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_full = {1'b0, q_r} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    next_q  = q_r;
    next_so = so_r;
    next_co = co_r;
    case (bus.mode)
      MODE_LOAD: next_q = bus.d;
      MODE_SHR: begin
        next_q  = {bus.sil, q_r[WIDTH-1:1]};
        next_so = q_r[0];
      end
      MODE_SHL: begin
        next_q  = {q_r[WIDTH-2:0], bus.sir};
        next_so = q_r[WIDTH-1];
      end
      MODE_ROR: begin
        next_q  = {q_r[0], q_r[WIDTH-1:1]};
        next_so = q_r[0];
      end
      MODE_ROL: begin
        next_q  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        next_so = q_r[WIDTH-1];
      end
      MODE_INC: begin
        next_q  = inc_full[WIDTH-1:0];
        next_co = inc_full[WIDTH];
      end
      MODE_DEC: begin
        next_q  = dec_full[WIDTH-1:0];
        next_co = dec_full[WIDTH];
      end
      default: begin
        next_q  = q_r;
        next_so = so_r;
        next_co = co_r;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_sre u_q (
      .c  (c),
      .rst(rst),
      .en (bus.en),
      .d  (next_q[i]),
      .q  (q_r[i])
    );
  end

  dff_sre u_so (
    .c  (c),
    .rst(rst),
    .en (bus.en),
    .d  (next_so),
    .q  (so_r)
  );

  dff_sre u_co (
    .c  (c),
    .rst(rst),
    .en (bus.en),
    .d  (next_co),
    .q  (co_r)
  );

  assign bus.q    = q_r;
  assign bus.so   = so_r;
  assign bus.co   = co_r;
  assign bus.zero = (q_r == '0);

endmodule

// File: doc/universal_register.md
# universal_register

Parametrised positive-edge register built from D flip-flop cells: WIDTH bits, one clock, synchronous active-high reset, clock enable and an eight-way mode select (hold, load, shift, rotate, count). It is the next generation of the single-bit DFlipFlop. Datapath and test designs use it wherever a plain flip-flop bank, shift register or counter is needed, without hand-wiring per-bit cells.

## Interface
- WIDTH, 4, number of stored bits; legal range 2..32

- c  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  clock enable; 0 means hold regardless of mode
- mode  in  3  operation select; encodings under Operation
- d  in  WIDTH  parallel load data
- sil  in  1  serial in, enters at bit WIDTH-1 on shift right
- sir  in  1  serial in, enters at bit 0 on shift left
- q  out  WIDTH  register contents
- so  out  1  registered copy of the bit most recently shifted or rotated out
- co  out  1  registered carry (inc) or borrow (dec) of the last count operation
- zero  out  1  combinational, 1 when q == 0

## Operation
- Priority at each rising edge: rst, then en, then mode.
- rst = 1: q = 0, so = 0, co = 0. Ignores en and mode.
- en = 0: q, so and co hold.
- mode 000 HOLD: q, so and co hold.
- mode 001 LOAD: q = d. so and co hold.
- mode 010 SHR: q = {sil, q[WIDTH-1:1]}, so = old q[0]. co holds.
- mode 011 SHL: q = {q[WIDTH-2:0], sir}, so = old q[WIDTH-1]. co holds.
- mode 100 ROR: q = {q[0], q[WIDTH-1:1]}, so = old q[0]. co holds.
- mode 101 ROL: q = {q[WIDTH-2:0], q[WIDTH-1]}, so = old q[WIDTH-1]. co holds.
- mode 110 INC: q = q + 1 modulo 2^WIDTH.
  - co = 1 only when old q was all ones (wrap to 0). Otherwise co = 0.
  - so holds.
- mode 111 DEC: q = q - 1 modulo 2^WIDTH.
  - co = 1 only when old q was 0 (wrap to all ones). Otherwise co = 0.
  - so holds.
- Arithmetic is unsigned, WIDTH bits. The carry is never retained in q.
- zero is derived from q only and carries no extra state.

## Timing
- Latency: one cycle. Inputs sampled at rising edge N appear on q, so and co after edge N.
- Between edges, q, so and co are stable regardless of input activity. This is flip-flop behaviour, not latch behaviour.
- zero follows q combinationally within the same cycle.
- Reset asserted mid-sequence (for example during counting) clears at the next edge. The operation requested on that edge is discarded.
- On the first edge after rst deasserts, the register operates normally.
- A mode change takes effect on the edge where the new mode is sampled. There is no pipeline and no multi-cycle state.
- Before the first reset, outputs are X or undefined. The bench applies rst at time 0.

## Structure
- Shared package holds the mode encodings as named constants: MODE_HOLD, MODE_LOAD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_INC, MODE_DEC.
- One sub-module, dff_sre: a single-bit rising-edge D flip-flop with synchronous reset and enable.
  - Instantiated WIDTH + 2 times: the q bits, so and co.
- Next-state selection is per-bit muxing plus a WIDTH-bit incrementer/decrementer with carry/borrow out.

## Test plan
- Reset and hold:
  - rst=1 with mode=001, d=1010 -> q=0000, so=0, co=0, zero=1.
  - Then rst=0, en=0, mode=001, d=1010 for 3 edges -> q stays 0000.
- Load then shift:
  - LOAD d=1011 -> q=1011.
  - SHR sil=0 -> q=0101, so=1.
  - SHL sir=1 -> q=1011, so=0.
- Rotate wrap: load 1000.
  - ROL -> q=0001, so=1.
  - ROR twice -> q=0100, so=0 after the final edge.
- Count wrap:
  - Load 1110. INC -> 1111, co=0. INC -> 0000, co=1, zero=1.
  - DEC -> 1111, co=1. DEC -> 1110, co=0.
- Reset mid-count: count INC from 0011 while asserting rst on the third edge -> q=0000, co=0. Counting resumes from 0001 on the next edge.
- Parameter sweep: WIDTH=2 and WIDTH=8.
  - Load all ones, INC -> q=0, co=1.
  - SHR sil=1 from 0 for WIDTH edges -> q all ones.
